// File: rtl/switch_allocator.sv
// switch_allocator: four wormhole round-robin arbiters, one per crossbar output.
// Each output locks to the winning input from head flit to tail flit and drives
// the crossbar select/enable. Per-input grants pop the input FIFOs.
// Optional feature macro ALLOC_TIMEOUT_EN: per-output stall counter that forces
// a lock release after TIMEOUT stalled cycles and pulses err_timeout.
module switch_allocator #(
  parameter int unsigned NPORT = 4
`ifdef ALLOC_TIMEOUT_EN
  ,
  parameter int unsigned TIMEOUT = 255
`endif
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_A,
  input  logic       req_B,
  input  logic       req_C,
  input  logic       req_D,
  input  logic [1:0] dest_A,
  input  logic [1:0] dest_B,
  input  logic [1:0] dest_C,
  input  logic [1:0] dest_D,
  input  logic       tail_A,
  input  logic       tail_B,
  input  logic       tail_C,
  input  logic       tail_D,
  input  logic       rdy_A,
  input  logic       rdy_B,
  input  logic       rdy_C,
  input  logic       rdy_D,
  output logic       gnt_A,
  output logic       gnt_B,
  output logic       gnt_C,
  output logic       gnt_D,
  output logic [1:0] sel_A,
  output logic [1:0] sel_B,
  output logic [1:0] sel_C,
  output logic [1:0] sel_D,
  output logic       en_A,
  output logic       en_B,
  output logic       en_C,
  output logic       en_D
`ifdef ALLOC_TIMEOUT_EN
  ,
  output logic       err_timeout
`endif
);

  logic [NPORT-1:0] req, tail, rdy;
  logic [1:0]       dest [NPORT];

  // Per-output arbitration state.
  logic [NPORT-1:0] lock_q;
  logic [1:0]       owner_q [NPORT];
  logic [1:0]       ptr_q   [NPORT];

  logic [NPORT-1:0] xfer;
  logic [NPORT-1:0] gnt;
  logic [NPORT-1:0] any_cand;
  logic [1:0]       winner [NPORT];

  assign req  = {req_D, req_C, req_B, req_A};
  assign tail = {tail_D, tail_C, tail_B, tail_A};
  assign rdy  = {rdy_D, rdy_C, rdy_B, rdy_A};
  assign dest[0] = dest_A;
  assign dest[1] = dest_B;
  assign dest[2] = dest_C;
  assign dest[3] = dest_D;

  // Transfer on a locked output only while its owner still targets it and downstream is ready.
  always_comb begin
    for (int o = 0; o < NPORT; o++) begin
      xfer[o] = lock_q[o] & req[owner_q[o]] & (dest[owner_q[o]] == 2'(o)) & rdy[o] & ~rst;
    end
  end

  // Grant an input when any output it owns moves a flit.
  always_comb begin
    gnt = '0;
    for (int i = 0; i < NPORT; i++) begin
      for (int o = 0; o < NPORT; o++) begin
        if (xfer[o] && (owner_q[o] == 2'(i))) gnt[i] = 1'b1;
      end
    end
  end

  // Round-robin pick: first requester for this output at or after ptr.
  always_comb begin
    for (int o = 0; o < NPORT; o++) begin
      logic       found;
      logic [1:0] idx;
      found     = 1'b0;
      idx       = '0;
      winner[o] = '0;
      any_cand[o] = 1'b0;
      for (int k = 0; k < NPORT; k++) begin
        idx = ptr_q[o] + 2'(k);
        if (!found && req[idx] && (dest[idx] == 2'(o))) begin
          found     = 1'b1;
          winner[o] = idx;
        end
      end
      any_cand[o] = found;
    end
  end

`ifdef ALLOC_TIMEOUT_EN
  localparam logic [7:0] TimeoutLast = 8'(TIMEOUT - 1);

  logic [7:0]       stall_q [NPORT];
  logic [NPORT-1:0] to_fire;
  logic             err_q;

  // A locked output that has stalled TIMEOUT cycles is released at this edge.
  always_comb begin
    for (int o = 0; o < NPORT; o++) begin
      to_fire[o] = lock_q[o] & ~xfer[o] & (stall_q[o] == TimeoutLast);
    end
  end

  // Stall counters and the registered timeout pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= 1'b0;
      for (int o = 0; o < NPORT; o++) stall_q[o] <= '0;
    end else begin
      err_q <= |to_fire;
      for (int o = 0; o < NPORT; o++) begin
        if (!lock_q[o] || xfer[o] || to_fire[o]) stall_q[o] <= '0;
        else                                     stall_q[o] <= stall_q[o] + 8'd1;
      end
    end
  end

  assign err_timeout = err_q;
`endif

  // Lock on arbitration win, release on tail transfer (or timeout); ptr moves only on release.
  always_ff @(posedge clk) begin
    if (rst) begin
      lock_q <= '0;
      for (int o = 0; o < NPORT; o++) begin
        owner_q[o] <= '0;
        ptr_q[o]   <= '0;
      end
    end else begin
      for (int o = 0; o < NPORT; o++) begin
        if (!lock_q[o]) begin
          if (any_cand[o]) begin
            lock_q[o]  <= 1'b1;
            owner_q[o] <= winner[o];
          end
        end else if (xfer[o] && tail[owner_q[o]]) begin
          lock_q[o] <= 1'b0;
          ptr_q[o]  <= owner_q[o] + 2'd1;
        end
`ifdef ALLOC_TIMEOUT_EN
        else if (to_fire[o]) begin
          lock_q[o] <= 1'b0;
          ptr_q[o]  <= owner_q[o] + 2'd1;
        end
`endif
      end
    end
  end

  assign {gnt_D, gnt_C, gnt_B, gnt_A} = gnt;
  assign {en_D, en_C, en_B, en_A}     = xfer;

  // Select follows the owner register, forced to zero while reset is asserted.
  assign sel_A = rst ? 2'b00 : owner_q[0];
  assign sel_B = rst ? 2'b00 : owner_q[1];
  assign sel_C = rst ? 2'b00 : owner_q[2];
  assign sel_D = rst ? 2'b00 : owner_q[3];

endmodule

// File: tb/tb_switch_allocator.sv
// Self-checking bench for switch_allocator: directed wormhole scenarios plus
// random traffic compared against a packet-level reference model.
module tb_switch_allocator;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req, tail, rdy;
  logic [7:0] dest;
  logic       gnt_A, gnt_B, gnt_C, gnt_D;
  logic       en_A, en_B, en_C, en_D;
  logic [1:0] sel_A, sel_B, sel_C, sel_D;

  always #5 clk = ~clk;

  switch_allocator dut (
    .clk    (clk),
    .rst    (rst),
    .req_A  (req[0]),
    .req_B  (req[1]),
    .req_C  (req[2]),
    .req_D  (req[3]),
    .dest_A (dest[1:0]),
    .dest_B (dest[3:2]),
    .dest_C (dest[5:4]),
    .dest_D (dest[7:6]),
    .tail_A (tail[0]),
    .tail_B (tail[1]),
    .tail_C (tail[2]),
    .tail_D (tail[3]),
    .rdy_A  (rdy[0]),
    .rdy_B  (rdy[1]),
    .rdy_C  (rdy[2]),
    .rdy_D  (rdy[3]),
    .gnt_A  (gnt_A),
    .gnt_B  (gnt_B),
    .gnt_C  (gnt_C),
    .gnt_D  (gnt_D),
    .sel_A  (sel_A),
    .sel_B  (sel_B),
    .sel_C  (sel_C),
    .sel_D  (sel_D),
    .en_A   (en_A),
    .en_B   (en_B),
    .en_C   (en_C),
    .en_D   (en_D)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: which input each output is reserved for, and whose turn is next.
  bit m_busy [4];
  int m_holder [4];
  int m_next [4];

  logic [3:0] obs_gnt, obs_en;
  logic [7:0] obs_sel;

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  // Apply one cycle of inputs, compare DUT outputs with the model mid-cycle, advance the model.
  task automatic run_cycle(input bit r, input logic [3:0] rq, input logic [7:0] ds,
                           input logic [3:0] tl, input logic [3:0] rd);
    logic [3:0] e_gnt, e_en;
    logic [7:0] e_sel;
    bit n_busy [4];
    int n_holder [4];
    int n_next [4];
    rst = r; req = rq; dest = ds; tail = tl; rdy = rd;
    #4;
    e_gnt = '0; e_en = '0; e_sel = '0;
    for (int o = 0; o < 4; o++) begin
      n_busy[o] = m_busy[o]; n_holder[o] = m_holder[o]; n_next[o] = m_next[o];
    end
    if (r) begin
      for (int o = 0; o < 4; o++) begin
        n_busy[o] = 0; n_holder[o] = 0; n_next[o] = 0;
      end
    end else begin
      for (int o = 0; o < 4; o++) begin
        e_sel[2*o +: 2] = 2'(m_holder[o]);
        if (m_busy[o]) begin
          int i = m_holder[o];
          if (rq[i] && (int'(ds[2*i +: 2]) == o) && rd[o]) begin
            e_en[o] = 1'b1;
            e_gnt[i] = 1'b1;
            if (tl[i]) begin
              n_busy[o] = 0;
              n_next[o] = (i + 1) % 4;
            end
          end
        end else begin
          for (int k = 0; k < 4; k++) begin
            int c = (m_next[o] + k) % 4;
            if (!n_busy[o] && rq[c] && (int'(ds[2*c +: 2]) == o)) begin
              n_busy[o] = 1;
              n_holder[o] = c;
            end
          end
        end
      end
    end
    obs_gnt = {gnt_D, gnt_C, gnt_B, gnt_A};
    obs_en  = {en_D, en_C, en_B, en_A};
    obs_sel = {sel_D, sel_C, sel_B, sel_A};
    check("gnt", obs_gnt, e_gnt);
    check("en", obs_en, e_en);
    check("sel", obs_sel, e_sel);
    for (int o = 0; o < 4; o++) begin
      m_busy[o] = n_busy[o]; m_holder[o] = n_holder[o]; m_next[o] = n_next[o];
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    int left [4];
    int sel_seq [$];
    int cyc_seq [$];
    logic [7:0] cur_dest;
    logic [3:0] rq, tl, rd;
    for (int o = 0; o < 4; o++) begin
      m_busy[o] = 0; m_holder[o] = 0; m_next[o] = 0;
    end
    rst = 1'b1; req = '0; dest = '0; tail = '0; rdy = '0;
    @(posedge clk);
    #1;

    // Single-flit packet A->C, then ptr_C must favour B over A.
    run_cycle(1, 4'b0000, 8'h00, 4'b0000, 4'b0000);
    check("rst_en", obs_en, 0);
    check("rst_sel", obs_sel, 0);
    run_cycle(0, 4'b0001, 8'b0000_0010, 4'b0001, 4'b0100);
    check("tp1_arb_en", obs_en, 0);
    check("tp1_arb_gnt", obs_gnt, 0);
    run_cycle(0, 4'b0001, 8'b0000_0010, 4'b0001, 4'b0100);
    check("tp1_xfer_en", obs_en, 4'b0100);
    check("tp1_xfer_gnt", obs_gnt, 4'b0001);
    check("tp1_sel_c", int'(obs_sel[5:4]), 0);
    run_cycle(0, 4'b0000, 8'b0000_0010, 4'b0000, 4'b0100);
    check("tp1_bubble_en", obs_en, 0);
    run_cycle(0, 4'b0011, 8'b0000_1010, 4'b0011, 4'b0100);
    run_cycle(0, 4'b0011, 8'b0000_1010, 4'b0011, 4'b0100);
    check("tp1_rr_gnt", obs_gnt, 4'b0010);
    check("tp1_rr_sel", int'(obs_sel[5:4]), 1);

    // A, B, D each send a 3-flit packet to output B.
    run_cycle(1, 4'b0000, 8'h00, 4'b0000, 4'b0000);
    left = '{3, 3, 0, 3};
    for (int cyc = 1; cyc <= 20; cyc++) begin
      for (int i = 0; i < 4; i++) begin
        rq[i] = (left[i] > 0);
        tl[i] = (left[i] == 1);
      end
      run_cycle(0, rq, 8'b0101_0101, tl, 4'hF);
      if (obs_en[1]) begin
        sel_seq.push_back(int'(obs_sel[3:2]));
        cyc_seq.push_back(cyc);
      end
      for (int i = 0; i < 4; i++) if (obs_gnt[i] && left[i] > 0) left[i]--;
    end
    check("tp2_flits", sel_seq.size(), 9);
    for (int k = 0; k < 9 && k < sel_seq.size(); k++) begin
      check("tp2_sel", sel_seq[k], (k < 3) ? 0 : (k < 6) ? 1 : 3);
      check("tp2_cycle", cyc_seq[k], 2 + k + k / 3);
    end

    // Random traffic, including protocol violations and occasional mid-packet resets.
    cur_dest = '0;
    for (int n = 0; n < 3000; n++) begin
      for (int i = 0; i < 4; i++) begin
        if ($urandom_range(0, 4) == 0) cur_dest[2*i +: 2] = 2'($urandom_range(0, 3));
        rq[i] = ($urandom_range(0, 3) != 0);
        tl[i] = ($urandom_range(0, 2) == 0);
        rd[i] = ($urandom_range(0, 4) != 0);
      end
      run_cycle(($urandom_range(0, 99) == 0), rq, cur_dest, tl, rd);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
